// File: rtl/comp_div.sv
`default_nettype none
// ============================================================================
// Module      : comp_div
// Description : Sequential unsigned restoring divider. Divides a 2*p_size-bit
//               dividend by a p_size-bit divisor, one quotient bit per clock,
//               using the same ena/dv handshake as the comp multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_div #(
    parameter int p_size = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*p_size-1:0]   i_param,
    input  logic [p_size-1:0]     i_param_2,
    input  logic                  ena,
    output logic [2*p_size-1:0]   o_param,
    output logic [p_size-1:0]     o_param_2,
    output logic                  dv,
    output logic                  busy,
    output logic                  dz
);

    localparam int C_W     = 2 * p_size;
    localparam int C_CNT_W = $clog2(C_W);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [C_CNT_W-1:0]  cnt_q,       cnt_d;
    logic [p_size:0]     rem_q,       rem_d;
    logic [C_W-1:0]      dvd_q,       dvd_d;
    logic [p_size-1:0]   dsr_q,       dsr_d;
    logic [p_size-1:0]   lo_q,        lo_d;
    logic                zero_q,      zero_d;
    logic [C_W-1:0]      o_param_q,   o_param_d;
    logic [p_size-1:0]   o_param_2_q, o_param_2_d;
    logic                dv_q,        dv_d;
    logic                busy_q,      busy_d;
    logic                dz_q,        dz_d;

    // One bit wider than the partial remainder so the sign of the trial
    // difference is the quotient-bit decision.
    logic [p_size+1:0]   rem_shift;
    logic [p_size+1:0]   trial;
    logic                q_bit;
    logic [p_size:0]     rem_next;
    logic [C_W-1:0]      dvd_next;

    // Next-state logic: capture in IDLE, one shift-subtract step per RUN cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        lo_d        = lo_q;
        zero_d      = zero_q;
        o_param_d   = o_param_q;
        o_param_2_d = o_param_2_q;
        dv_d        = 1'b0;
        busy_d      = busy_q;
        dz_d        = dz_q;

        rem_shift = {rem_q, dvd_q[C_W-1]};
        trial     = rem_shift - {2'b00, dsr_q};
        q_bit     = ~trial[p_size+1];
        rem_next  = q_bit ? trial[p_size:0] : rem_shift[p_size:0];
        // Quotient bits fill the dividend LSBs as they are vacated.
        dvd_next  = {dvd_q[C_W-2:0], q_bit};

        case (state_q)
            IDLE: begin
                if (ena) begin
                    dvd_d   = i_param;
                    dsr_d   = i_param_2;
                    lo_d    = i_param[p_size-1:0];
                    rem_d   = '0;
                    cnt_d   = C_LAST;
                    zero_d  = (i_param_2 == '0);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                if (cnt_q == '0) begin
                    // Divide by zero still runs full length; results are forced.
                    o_param_d   = zero_q ? '1   : dvd_next;
                    o_param_2_d = zero_q ? lo_q : rem_next[p_size-1:0];
                    dz_d        = zero_q;
                    dv_d        = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            lo_q        <= '0;
            zero_q      <= 1'b0;
            o_param_q   <= '0;
            o_param_2_q <= '0;
            dv_q        <= 1'b0;
            busy_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            lo_q        <= lo_d;
            zero_q      <= zero_d;
            o_param_q   <= o_param_d;
            o_param_2_q <= o_param_2_d;
            dv_q        <= dv_d;
            busy_q      <= busy_d;
            dz_q        <= dz_d;
        end
    end

    assign o_param   = o_param_q;
    assign o_param_2 = o_param_2_q;
    assign dv        = dv_q;
    assign busy      = busy_q;
    assign dz        = dz_q;

endmodule
`default_nettype wire
